// File: rtl/usequencer_if.sv
// Sequencer-side bus: opcode and ROM handshake in, microinstruction and step status out.
// master = sequencer, slave = CPU/ROM environment driving opcode, ROM data and stall.
interface usequencer_if;
    logic [7:0]  ir_opcode;
    logic [10:0] urom_addr;
    logic [15:0] urom_data;
    logic        stall;
    logic [15:0] uinstr;
    logic [2:0]  tstate;
    logic        fetch;
    logic [15:0] instr_count;

    modport master (
        input  ir_opcode, urom_data, stall,
        output urom_addr, uinstr, tstate, fetch, instr_count
    );

    modport slave (
        output ir_opcode, urom_data, stall,
        input  urom_addr, uinstr, tstate, fetch, instr_count
    );
endinterface

// File: rtl/usequencer.sv
// SCAMP microinstruction sequencer: T-state counter plus word select (fetch words, async ROM, NOP).
// uinstr is combinational from registered step (zero latency); stall holds state and emits NOP.
module usequencer #(
    parameter logic [15:0] FETCH0   = 16'h8020,
    parameter logic [15:0] FETCH1   = 16'hB440,
    parameter logic [15:0] NOP_WORD = 16'h8000
) (
    input  logic         clk,
    input  logic         reset,
    usequencer_if.master seq_if
);

    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4,
        T5 = 3'd5,
        T6 = 3'd6,
        T7 = 3'd7
    } step_e;

    step_e       step_q;
    step_e       step_d;
    logic [15:0] count_q;
    logic [15:0] count_d;
    logic [15:0] uinstr_w;
    logic        rt_w;
    logic        end_instr_w;

    always_comb begin
        uinstr_w = seq_if.urom_data;
        if (reset || seq_if.stall) begin
            uinstr_w = NOP_WORD;
        end else if (step_q == T0) begin
            uinstr_w = FETCH0;
        end else if (step_q == T1) begin
            uinstr_w = FETCH1;
        end
    end

    // Bit 11 is RT only with bit 15 set; otherwise it is the NY jump bit.
    assign rt_w        = uinstr_w[15] & uinstr_w[11];
    assign end_instr_w = rt_w || (step_q == T7);

    always_comb begin
        step_d  = step_q;
        count_d = count_q;
        if (!seq_if.stall) begin
            if (end_instr_w) begin
                step_d  = T0;
                count_d = count_q + 16'd1;
            end else begin
                step_d = step_e'(step_q + 3'd1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            step_q  <= T0;
            count_q <= '0;
        end else begin
            step_q  <= step_d;
            count_q <= count_d;
        end
    end

    // The opcode is used as-is: IR loads at the end of T1, so T2 addressing sees it directly.
    assign seq_if.urom_addr   = {seq_if.ir_opcode, step_q};
    assign seq_if.uinstr      = uinstr_w;
    assign seq_if.tstate      = step_q;
    assign seq_if.fetch       = (step_q == T0) || (step_q == T1);
    assign seq_if.instr_count = count_q;

endmodule
